fdct_8x8_stream: RTL and testbench
==================================

Name: fdct_8x8_stream

Overview:
- Forward 2-D 8x8 DCT. It is the encoder-side counterpart of the Fast_IDCT coefficient path.
- Accepts a block of 8 residual rows (one row per beat) and emits 8 coefficient columns (one column per beat).
- Separable row/column integer DCT with a ping-pong transpose buffer, sustaining 1 beat/cycle throughput.
- Coefficients are clipped to 12-bit signed, the IDCT input range.

Parameters:
- ML, 16, lane width in bits (input samples, intermediate values and output coefficients).
- CLIP, 2047, output saturation bound; outputs are clamped to [-CLIP-1, CLIP].

Ports:
- clk  input  1  clock; one clock, all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  in_data holds a valid row.
- in_ready  output  1  block can accept a row.
- in_data  input  8*ML  row samples s[y][x]; lane x at bits [ML*x+ML-1 : ML*x]; signed.
- out_valid  output  1  out_data holds a valid column.
- out_ready  input  1  sink accepts the column.
- out_data  output  8*ML  coefficient column k; lane u = F[u][k]; signed.
- out_last  output  1  high with column 7 of each block.

Behaviour:
- Handshakes:
  - A beat transfers on any rising edge with valid & ready.
  - The input row counter (0..7, wraps) increments per input beat; no framing signal is needed.
  - Once out_valid is high, out_data, out_last and out_valid hold stable until out_ready.
- Coefficient table: C[u][x] = round-half-away-from-zero(4096 * c(u)/2 * cos((2x+1)u*pi/16)), with c(0)=1/sqrt2 and c(u>0)=1. The table is a 13-bit signed constant (C[0][x] = 1448).
- Row pass (combinational on in_data):
  - R[y][u] = (sum_x C[u][x]*s[y][x] + 1024) >>> 11.
  - 32-bit signed accumulate, arithmetic (floor) shift.
  - Saturate to ML-bit signed.
  - Written into the current write bank, row y, on the accepting edge.
- Column pass: F[u][k] = clamp((sum_y C[u][y]*R[y][k] + 4096) >>> 13, -CLIP-1, CLIP). It is computed from the read bank and registered into out_data.
- Transpose buffer:
  - Two banks of 8x8xML.
  - Each bank has its own state machine: EMPTY -> FILLING (first row written) -> FULL (row 7 written) -> DRAINING (column 0 loaded to output) -> EMPTY (column 7 handed off to the output register).
  - Write pointer toggles on row 7; read pointer toggles on column 7.
  - in_ready = 1 iff the write bank is EMPTY or FILLING.
- Latency: if row 7 transfers in cycle n and the read bank was idle, column 0 appears with out_valid=1 in cycle n+2. With out_ready held high, columns 1..7 follow in cycles n+3..n+9.
- Throughput: back-to-back blocks with out_ready=1 give in_ready permanently high (8 cycles/block).
- Backpressure: out_ready=0 freezes the output register and the column counter. If both banks are FULL/DRAINING, in_ready drops until the draining bank empties. No beat is ever lost or duplicated.
- Simultaneous events in one cycle:
  - Row 7 written to bank A while column 7 leaves bank B: both transitions take effect.
  - Column 0 of bank A loads in the next cycle.
- Reset, applied in any cycle including mid-block:
  - Next edge gives both banks EMPTY, all counters 0, pointers 0, out_valid=0, out_last=0, out_data=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Partial blocks are discarded; bank contents need no clearing.

Optional Feature:
- Macro: FDCT_SAT_EN.
- Defined:
  - Adds output port out_sat (1 bit).
  - Registered alongside out_data; high on a column beat if any lane of that column clipped in the column pass, or any R[y][k] it consumed saturated in the row pass.
  - Reset value 0; held with out_data under backpressure.
- Undefined: port absent. Clipping and saturation behave identically.

Test Plan:
- Reset, then an all-zero block with out_ready=1 -> 8 columns of all-zero lanes; out_last only on column 7; first out_valid exactly 2 cycles after row 7 transfers.
- Constant block s=100 -> F[0][0]=800 (row pass gives R=566); every other coefficient 0.
- Constant block s=255 -> F[0][0]=2039, all others 0. Constant s=1000 -> F[0][0]=2047 (clamped) and, with FDCT_SAT_EN, out_sat=1 on column 0 only.
- Three back-to-back blocks (100, 0, 255), in_valid and out_ready always 1 -> in_ready never drops; 24 output beats in order; DC values 800, 0, 2039.
- out_ready toggled pseudo-randomly, in_valid always 1, 4 blocks -> data stable during stalls; in_ready low only while both banks are occupied; outputs match the golden integer model bit-exactly.
- Assert rst_n=0 for one cycle after row 4 of block 1 (block 0 draining) -> out_valid=0 next cycle; a following full block of s=100 yields exactly one block with DC 800, with no residue from the aborted data.

Source files
------------

// File: rtl/fdct_8x8_stream.sv
// fdct_8x8_stream
// Forward 2-D 8x8 DCT with streaming row input and column output. A row pass
// turns each input row into a row of intermediate values. That row is written
// into a ping-pong transpose buffer. A column pass then reads one column per
// beat from the other bank, clips it and registers it as an output coefficient
// column.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   in_data carries a valid row
//   in_ready   a row can be accepted (write bank EMPTY or FILLING)
//   in_data    row samples s[y][x], lane x at [ML*x +: ML], signed
//   out_valid  out_data carries a valid coefficient column
//   out_ready  sink accepts the column
//   out_data   coefficient column k, lane u = F[u][k], signed
//   out_last   high with column 7 of each block
//   out_sat    (only with FDCT_SAT_EN) the column clipped or consumed a
//              saturated row-pass value
//
// Optional feature macro: FDCT_SAT_EN adds the out_sat port.
//
// Handshake: a beat moves on any rising edge where valid and ready are both
// high. Once out_valid is high, out_data/out_last (and out_sat) stay unchanged
// until out_ready accepts them. in_ready depends only on registered state.

module fdct_8x8_stream #(
  parameter int ML   = 16,
  parameter int CLIP = 2047
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8*ML-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8*ML-1:0] out_data,
`ifdef FDCT_SAT_EN
  output logic            out_sat,
`endif
  output logic            out_last
);

  localparam int MAXV = (1 <<< (ML - 1)) - 1;
  localparam int MINV = -(1 <<< (ML - 1));

  // C[u][x] = round(4096 * c(u)/2 * cos((2x+1)u*pi/16))
  localparam logic signed [12:0] COEF [8][8] = '{
    '{ 13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448},
    '{ 13'sd2009,  13'sd1703,  13'sd1138,  13'sd400,  -13'sd400,  -13'sd1138, -13'sd1703, -13'sd2009},
    '{ 13'sd1892,  13'sd784,  -13'sd784,  -13'sd1892, -13'sd1892, -13'sd784,   13'sd784,   13'sd1892},
    '{ 13'sd1703, -13'sd400,  -13'sd2009, -13'sd1138,  13'sd1138,  13'sd2009,  13'sd400,  -13'sd1703},
    '{ 13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448,  13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448},
    '{ 13'sd1138, -13'sd2009,  13'sd400,   13'sd1703, -13'sd1703, -13'sd400,   13'sd2009, -13'sd1138},
    '{ 13'sd784,  -13'sd1892,  13'sd1892, -13'sd784,  -13'sd784,   13'sd1892, -13'sd1892,  13'sd784},
    '{ 13'sd400,  -13'sd1138,  13'sd1703, -13'sd2009,  13'sd2009, -13'sd1703,  13'sd1138, -13'sd400}
  };

  typedef enum logic [1:0] {
    B_EMPTY    = 2'd0,
    B_FILLING  = 2'd1,
    B_FULL     = 2'd2,
    B_DRAINING = 2'd3
  } bank_st_t;

  // All control state lives in one struct so checkers can observe it whole.
  typedef struct packed {
    bank_st_t   st1;     // bank 1 state
    bank_st_t   st0;     // bank 0 state
    logic       wp;      // bank receiving rows
    logic       rp;      // bank feeding the column pass
    logic [2:0] wr_row;  // next row to write
    logic [2:0] rd_col;  // next column to load into the output register
  } ctl_t;

  ctl_t ctl_q, ctl_d;

  logic signed [ML-1:0] bank [2][8][8];  // [bank][row y][column]
  logic signed [ML-1:0] row_r [8];       // row-pass result for the current input row
  logic [8*ML-1:0]      col_word;        // column-pass result for the read column
  bank_st_t             wr_st, rd_st;
  logic                 wr_fire, ld_fire;

`ifdef FDCT_SAT_EN
  logic [7:0] row_sat;                   // per lane: row-pass value saturated
  logic       col_clip;                  // any lane of the column clipped
  logic [7:0] col_sat [2];               // per bank, per column: a consumed R saturated
`endif

  assign wr_st    = ctl_q.wp ? ctl_q.st1 : ctl_q.st0;
  assign rd_st    = ctl_q.rp ? ctl_q.st1 : ctl_q.st0;
  assign in_ready = (wr_st == B_EMPTY) || (wr_st == B_FILLING);
  assign wr_fire  = in_valid && in_ready;
  // Load the output register whenever a filled bank has columns left and the
  // register is empty or being emptied on this edge.
  assign ld_fire  = ((rd_st == B_FULL) || (rd_st == B_DRAINING)) && (!out_valid || out_ready);

  function automatic bank_st_t bank_next(input bank_st_t st, input logic wr, input logic rd,
                                         input logic wr_last, input logic rd_last);
    bank_st_t nx;
    nx = st;
    case (st)
      B_EMPTY:    if (wr)            nx = B_FILLING;
      B_FILLING:  if (wr && wr_last) nx = B_FULL;
      B_FULL:     if (rd)            nx = B_DRAINING;
      B_DRAINING: if (rd && rd_last) nx = B_EMPTY;
      default:                       nx = B_EMPTY;
    endcase
    return nx;
  endfunction

  // Next-state logic. A write and a load can never target the same bank in
  // one cycle because they require disjoint bank states, so the two bank
  // transitions (and pointer toggles) are independent.
  always_comb begin
    ctl_d = ctl_q;
    if (wr_fire) begin
      ctl_d.wr_row = ctl_q.wr_row + 3'd1;
      if (ctl_q.wr_row == 3'd7) ctl_d.wp = ~ctl_q.wp;
    end
    if (ld_fire) begin
      ctl_d.rd_col = ctl_q.rd_col + 3'd1;
      if (ctl_q.rd_col == 3'd7) ctl_d.rp = ~ctl_q.rp;
    end
    ctl_d.st0 = bank_next(ctl_q.st0, wr_fire && !ctl_q.wp, ld_fire && !ctl_q.rp,
                          ctl_q.wr_row == 3'd7, ctl_q.rd_col == 3'd7);
    ctl_d.st1 = bank_next(ctl_q.st1, wr_fire && ctl_q.wp, ld_fire && ctl_q.rp,
                          ctl_q.wr_row == 3'd7, ctl_q.rd_col == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ctl_q <= '0;
    else        ctl_q <= ctl_d;
  end

  // Row pass: R[y][u] = sat_ML((sum_x C[u][x]*s[y][x] + 1024) >>> 11)
  always_comb begin
    int acc;
    acc = 0;
`ifdef FDCT_SAT_EN
    row_sat = '0;
`endif
    for (int u = 0; u < 8; u++) begin
      acc = 1024;
      for (int x = 0; x < 8; x++)
        acc = acc + int'(COEF[u][x]) * int'($signed(in_data[ML*x +: ML]));
      acc = acc >>> 11;
`ifdef FDCT_SAT_EN
      row_sat[u] = (acc > MAXV) || (acc < MINV);
`endif
      if (acc > MAXV)      row_r[u] = ML'(MAXV);
      else if (acc < MINV) row_r[u] = ML'(MINV);
      else                 row_r[u] = ML'(acc);
    end
  end

  // Bank contents are not reset: a bank is always fully rewritten before it
  // is read, so stale data from an aborted block is never consumed.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int u = 0; u < 8; u++) begin
        bank[ctl_q.wp][ctl_q.wr_row][u] <= row_r[u];
`ifdef FDCT_SAT_EN
        // Row 0 restarts the per-column saturation history for this bank.
        col_sat[ctl_q.wp][u] <= ((ctl_q.wr_row == 3'd0) ? 1'b0 : col_sat[ctl_q.wp][u]) | row_sat[u];
`endif
      end
    end
  end

  // Column pass: F[u][k] = clamp((sum_y C[u][y]*R[y][k] + 4096) >>> 13)
  always_comb begin
    int acc;
    acc      = 0;
    col_word = '0;
`ifdef FDCT_SAT_EN
    col_clip = 1'b0;
`endif
    for (int u = 0; u < 8; u++) begin
      acc = 4096;
      for (int y = 0; y < 8; y++)
        acc = acc + int'(COEF[u][y]) * int'(bank[ctl_q.rp][y][ctl_q.rd_col]);
      acc = acc >>> 13;
`ifdef FDCT_SAT_EN
      if ((acc > CLIP) || (acc < -CLIP - 1)) col_clip = 1'b1;
`endif
      if (acc > CLIP)           acc = CLIP;
      else if (acc < -CLIP - 1) acc = -CLIP - 1;
      col_word[ML*u +: ML] = ML'(acc);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
`ifdef FDCT_SAT_EN
      out_sat   <= 1'b0;
`endif
    end else if (ld_fire) begin
      out_valid <= 1'b1;
      out_last  <= (ctl_q.rd_col == 3'd7);
      out_data  <= col_word;
`ifdef FDCT_SAT_EN
      out_sat   <= col_clip | col_sat[ctl_q.rp][ctl_q.rd_col];
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fdct_8x8_stream.sv
// Testbench for fdct_8x8_stream: driver tasks feed rows; expected columns
// come from a floating-point-derived integer DCT reference and go into a
// queue; a negedge monitor pops and compares every accepted output beat and
// watches stall stability.

module tb_fdct_8x8_stream;

  localparam int ML = 16;
  localparam int EW = 8*ML + 2;  // {sat, last, data}

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [8*ML-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [8*ML-1:0] out_data;
  logic            out_last;
`ifdef FDCT_SAT_EN
  logic            out_sat;
`endif

  fdct_8x8_stream #(.ML(ML), .CLIP(2047)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef FDCT_SAT_EN
    .out_sat   (out_sat),
`endif
    .out_last  (out_last)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  int   dc_seen[$];
  int   beats      = 0;
  int   rx_idx     = 0;
  int   ready_drop = 0;
  bit   chk_ready  = 0;
  bit   rand_rdy   = 0;
  int   coef_m [8][8];
  int   cur_blk [8][8];

  task automatic check(input string name, input logic ok,
                       input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void build_table();
    for (int u = 0; u < 8; u++)
      for (int x = 0; x < 8; x++) begin
        real cu, v;
        cu = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        v  = 4096.0 * cu / 2.0 * $cos((2.0*x + 1.0) * u * 3.14159265358979 / 16.0);
        coef_m[u][x] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
      end
  endfunction

  // Compute the whole block as matrices and queue its 8 output columns.
  task automatic push_model();
    int r [8][8];
    bit rs [8][8];
    int f [8][8];
    bit fc [8][8];
    for (int y = 0; y < 8; y++)
      for (int u = 0; u < 8; u++) begin
        int acc;
        acc = 1024;
        for (int x = 0; x < 8; x++) acc += coef_m[u][x] * cur_blk[y][x];
        acc = acc >>> 11;
        rs[y][u] = (acc > 32767) || (acc < -32768);
        r[y][u]  = (acc > 32767) ? 32767 : (acc < -32768) ? -32768 : acc;
      end
    for (int u = 0; u < 8; u++)
      for (int k = 0; k < 8; k++) begin
        int acc;
        acc = 4096;
        for (int y = 0; y < 8; y++) acc += coef_m[u][y] * r[y][k];
        acc = acc >>> 13;
        fc[u][k] = (acc > 2047) || (acc < -2048);
        f[u][k]  = (acc > 2047) ? 2047 : (acc < -2048) ? -2048 : acc;
      end
    for (int k = 0; k < 8; k++) begin
      logic [EW-1:0] e;
      bit s;
      s = 0;
      e = '0;
      for (int u = 0; u < 8; u++) begin
        e[ML*u +: ML] = ML'(f[u][k]);
        s = s | fc[u][k] | rs[u][k];
      end
      e[8*ML]   = (k == 7);
      e[8*ML+1] = s;
      exp_q.push_back(e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill_const(input int v);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) cur_blk[y][x] = v;
  endtask

  task automatic fill_rand(input bit wide);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        cur_blk[y][x] = wide ? (int'($urandom_range(0, 65535)) - 32768)
                             : (int'($urandom_range(0, 511)) - 256);
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the last row transferred.
  task automatic send_rows(input int nrows);
    for (int y = 0; y < nrows; y++) begin
      int w;
      in_valid = 1'b1;
      for (int x = 0; x < 8; x++) in_data[ML*x +: ML] = ML'(cur_blk[y][x]);
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 300) begin
        @(negedge clk);
        w++;
      end
      if (w >= 300) begin
        check("in_ready_timeout", 1'b0, EW'(in_ready), EW'(1));
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_block();
    push_model();
    send_rows(8);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("drain_timeout", w < 3000, EW'(exp_q.size()), EW'(0));
  endtask

  // ---------------- out_ready driver ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [EW-1:0] held_v;
  bit            held = 0;

  function automatic logic [EW-1:0] cur_out();
    logic [EW-1:0] v;
    v = {1'b0, out_last, out_data};
`ifdef FDCT_SAT_EN
    v[8*ML+1] = out_sat;
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      held   = 0;
      rx_idx = 0;
    end else begin
      if (chk_ready && in_valid && !in_ready) ready_drop++;
      if (held)
        check("stall_hold", out_valid && (cur_out() == held_v), cur_out(), held_v);
      if (out_valid) begin
        if (out_ready) begin
          held = 0;
          beats++;
          if (rx_idx == 0) dc_seen.push_back(int'($signed(out_data[ML-1:0])));
          rx_idx = (rx_idx + 1) % 8;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1'b0, cur_out(), '0);
          end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("col_data", out_data == e[8*ML-1:0], EW'(out_data), EW'(e[8*ML-1:0]));
            check("col_last", out_last == e[8*ML], EW'(out_last), EW'(e[8*ML]));
`ifdef FDCT_SAT_EN
            check("col_sat", out_sat == e[8*ML+1], EW'(out_sat), EW'(e[8*ML+1]));
`endif
          end
        end else begin
          held   = 1;
          held_v = cur_out();
        end
      end else begin
        held = 0;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int dc_exp [7];
    dc_exp = '{0, 800, 2039, 2047, 800, 0, 2039};
    build_table();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid == 1'b0, EW'(out_valid), EW'(0));
    check("rst_out_last", out_last == 1'b0, EW'(out_last), EW'(0));
    check("rst_out_data", out_data == '0, EW'(out_data), EW'(0));
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready == 1'b1, EW'(in_ready), EW'(1));

    // Zero block with latency check.
    fill_const(0);
    send_block();
    check("latency_n1", out_valid == 1'b0, EW'(out_valid), EW'(0));
    @(posedge clk);
    #1;
    check("latency_n2", out_valid == 1'b1, EW'(out_valid), EW'(1));
    wait_drain();

    // Constant blocks, one at a time.
    fill_const(100);  send_block(); wait_drain();
    fill_const(255);  send_block(); wait_drain();
    fill_const(1000); send_block(); wait_drain();

    // Back-to-back blocks with in_valid held high.
    chk_ready = 1;
    fill_const(100); send_block();
    fill_const(0);   send_block();
    fill_const(255); send_block();
    chk_ready = 0;
    wait_drain();
    check("b2b_ready_drops", ready_drop == 0, EW'(ready_drop), EW'(0));
    check("dc_count", dc_seen.size() == 7, EW'(dc_seen.size()), EW'(7));
    for (int i = 0; i < 7; i++)
      if (i < dc_seen.size())
        check("dc_value", dc_seen[i] == dc_exp[i], EW'(dc_seen[i]), EW'(dc_exp[i]));

    // Random data under random backpressure.
    rand_rdy = 1;
    for (int b = 0; b < 4; b++) begin
      fill_rand(b[0]);
      send_block();
    end
    wait_drain();
    rand_rdy = 0;
    @(posedge clk);
    #1;

    // Mid-block reset while the previous block drains.
    fill_rand(1'b0);
    send_block();
    fill_rand(1'b1);
    send_rows(5);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    check("midrst_out_valid", out_valid == 1'b0, EW'(out_valid), EW'(0));
    check("midrst_in_ready", in_ready == 1'b1, EW'(in_ready), EW'(1));
    dc_seen.delete();
    beats = 0;
    fill_const(100);
    send_block();
    wait_drain();
    repeat (20) @(posedge clk);
    #1;
    check("midrst_beats", beats == 8, EW'(beats), EW'(8));
    check("midrst_dc_count", dc_seen.size() == 1, EW'(dc_seen.size()), EW'(1));
    if (dc_seen.size() > 0)
      check("midrst_dc", dc_seen[0] == 800, EW'(dc_seen[0]), EW'(800));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    check("global_timeout", 1'b0, '0, '1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
